// File: rtl/lcd_text_feeder.sv
// Character FIFO and cursor tracker that turns an ASCII stream into paced
// {rs, data} words for the LCD driver's data_ready / busy_flag handshake.
module lcd_text_feeder #(
  parameter int DEPTH       = 16,
  parameter int COLS        = 16,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                     clock,
  input  logic                     internal_reset,
  input  logic [7:0]               char_in,
  input  logic                     char_valid,
  output logic                     char_ready,
  input  logic                     lcd_busy,
  output logic [8:0]               lcd_d_in,
  output logic                     lcd_data_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(COLS + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW:0]   FULL_C  = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] COLS_C  = CW'(COLS);
  localparam logic [TW-1:0] TLAST_C = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    WAIT_INIT,
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  state_t        state_q, state_d;
  logic          seen_busy_q, seen_busy_d;
  logic          row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [8:0]    cur_word_q, cur_word_d;
  logic [8:0]    next_word_q, next_word_d;
  logic          second_q, second_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          push, pop, printable;
  logic [7:0]    head;

  assign char_ready     = (count_q < FULL_C);
  assign push           = char_valid && char_ready;
  assign head           = mem_q[rd_ptr_q];
  assign printable      = (head >= 8'h20) && (head <= 8'h7E);
  assign fifo_count     = count_q;
  assign lcd_d_in       = cur_word_q;
  assign lcd_data_ready = (state_q == ISSUE);
  assign idle           = (state_q == IDLE) && (count_q == '0);

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= char_in;
    end
  end

  always_ff @(posedge clock) begin
    if (internal_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= WAIT_INIT;
      seen_busy_q <= 1'b0;
      row_q       <= 1'b0;
      col_q       <= '0;
      cur_word_q  <= '0;
      next_word_q <= '0;
      second_q    <= 1'b0;
      timer_q     <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + (AW + 1)'(1);
      end else if (pop && !push) begin
        count_q <= count_q - (AW + 1)'(1);
      end
      state_q     <= state_d;
      seen_busy_q <= seen_busy_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cur_word_q  <= cur_word_d;
      next_word_q <= next_word_d;
      second_q    <= second_d;
      timer_q     <= timer_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    seen_busy_d = seen_busy_q;
    row_d       = row_q;
    col_d       = col_q;
    cur_word_d  = cur_word_q;
    next_word_d = next_word_q;
    second_d    = second_q;
    timer_d     = timer_q;
    pop         = 1'b0;
    case (state_q)
      WAIT_INIT: begin
        if (lcd_busy) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        // Only pop while the driver is free, so a busy driver backs up the FIFO.
        if ((count_q != '0) && !lcd_busy) begin
          pop = 1'b1;
          if (printable) begin
            if (col_q == COLS_C) begin
              cur_word_d  = {1'b0, 1'b1, ~row_q, 6'b0};
              next_word_d = {1'b1, head};
              second_d    = 1'b1;
              row_d       = ~row_q;
              col_d       = CW'(1);
            end else begin
              cur_word_d = {1'b1, head};
              second_d   = 1'b0;
              col_d      = col_q + CW'(1);
            end
            state_d = ISSUE;
          end else if (head == 8'h0A) begin
            cur_word_d = {1'b0, 1'b1, ~row_q, 6'b0};
            second_d   = 1'b0;
            row_d      = ~row_q;
            col_d      = '0;
            state_d    = ISSUE;
          end else if (head == 8'h0C) begin
            cur_word_d = 9'h001;
            second_d   = 1'b0;
            row_d      = 1'b0;
            col_d      = '0;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (lcd_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TLAST_C) begin
          state_d = ISSUE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!lcd_busy) begin
          if (second_q) begin
            cur_word_d = next_word_q;
            second_d   = 1'b0;
            state_d    = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = WAIT_INIT;
    endcase
  end

endmodule

// File: tb/tb_lcd_text_feeder.sv
// Directed bench for lcd_text_feeder: a driver model answers strobes, expected
// words are queued as characters are pushed and compared as strobes arrive.
module tb_lcd_text_feeder;

  logic       clock = 1'b0;
  logic       internal_reset = 1'b1;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic       lcd_busy;
  logic [8:0] lcd_d_in;
  logic       lcd_data_ready;
  logic [4:0] fifo_count;
  logic       idle;

  logic force_busy = 1'b0;
  logic resp_busy  = 1'b0;
  assign lcd_busy = force_busy | resp_busy;

  int checks = 0;
  int errors = 0;
  int resp_len = 3;
  int ignore_target = 0;
  int n_ign = 0;
  int n_strobes = 0;
  int busy_cnt = 0;
  int cyc = 0;
  bit prev_rdy = 1'b0;
  logic [8:0] log_word [512];
  bit         log_busy [512];
  bit         log_double [512];
  bit         log_ign [512];
  int         log_cyc [512];
  logic [8:0] exp_q [$];
  int rd_idx = 0;

  always #5 clock = ~clock;

  lcd_text_feeder #(.DEPTH(16), .COLS(16), .ACK_TIMEOUT(64)) dut (
    .clock          (clock),
    .internal_reset (internal_reset),
    .char_in        (char_in),
    .char_valid     (char_valid),
    .char_ready     (char_ready),
    .lcd_busy       (lcd_busy),
    .lcd_d_in       (lcd_d_in),
    .lcd_data_ready (lcd_data_ready),
    .fifo_count     (fifo_count),
    .idle           (idle)
  );

  // Driver model: logs every strobe, optionally ignores some, else goes busy.
  always @(negedge clock) begin
    cyc++;
    if (internal_reset) begin
      resp_busy = 1'b0;
      busy_cnt  = 0;
      prev_rdy  = 1'b0;
    end else begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) resp_busy = 1'b0;
      end
      if (lcd_data_ready && n_strobes < 512) begin
        log_word[n_strobes]   = lcd_d_in;
        log_busy[n_strobes]   = lcd_busy;
        log_double[n_strobes] = prev_rdy;
        log_cyc[n_strobes]    = cyc;
        if (n_ign < ignore_target) begin
          n_ign++;
          log_ign[n_strobes] = 1'b1;
        end else begin
          log_ign[n_strobes] = 1'b0;
          resp_busy = 1'b1;
          busy_cnt  = resp_len;
        end
        n_strobes++;
      end
      prev_rdy = lcd_data_ready;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_word(input logic [8:0] w);
    exp_q.push_back(w);
  endtask

  task automatic push_char(input logic [7:0] c);
    int n = 0;
    while (!char_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!char_ready) chk("push_ready_timeout", {31'b0, char_ready}, 32'd1);
    char_in    = c;
    char_valid = 1'b1;
    @(negedge clock);
    char_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!(idle && !lcd_busy) && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_idle"}, {31'b0, idle}, 32'd1);
  endtask

  task automatic drain();
    while (rd_idx < n_strobes) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {23'b0, log_word[rd_idx]}, 32'hFFFF_FFFF);
      end else begin
        chk("word", {23'b0, log_word[rd_idx]}, {23'b0, exp_q[0]});
        if (!log_ign[rd_idx]) void'(exp_q.pop_front());
      end
      chk("strobe_while_busy", {31'b0, log_busy[rd_idx]}, 32'd0);
      chk("strobe_width", {31'b0, log_double[rd_idx]}, 32'd0);
      rd_idx++;
    end
  endtask

  initial begin
    int base;
    int acc;

    internal_reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_d_in", {23'b0, lcd_d_in}, 32'd0);
    chk("rst_data_ready", {31'b0, lcd_data_ready}, 32'd0);
    chk("rst_count", {27'b0, fifo_count}, 32'd0);
    chk("rst_idle", {31'b0, idle}, 32'd0);
    chk("rst_char_ready", {31'b0, char_ready}, 32'd1);
    internal_reset = 1'b0;

    force_busy = 1'b1;
    repeat (20) @(negedge clock);
    force_busy = 1'b0;
    chk("init_no_strobe", n_strobes, 0);
    chk("init_not_idle", {31'b0, idle}, 32'd0);

    expect_word(9'h148);
    expect_word(9'h169);
    push_char(8'h48);
    push_char(8'h69);
    wait_idle("hi", 1000);
    drain();
    chk("hi_strobes", n_strobes, 2);

    expect_word(9'h001);
    push_char(8'h0C);
    expect_word(9'h0C0);
    push_char(8'h0A);
    expect_word(9'h158);
    push_char(8'h58);
    push_char(8'h07);
    expect_word(9'h001);
    push_char(8'h0C);
    wait_idle("ctrl", 1000);
    drain();
    chk("ctrl_strobes", n_strobes, 6);
    chk("ctrl_idle_end", {31'b0, idle}, 32'd1);

    for (int i = 0; i < 16; i++) expect_word(9'h141);
    expect_word(9'h0C0);
    expect_word(9'h141);
    for (int i = 0; i < 17; i++) push_char(8'h41);
    expect_word(9'h080);
    push_char(8'h0A);
    expect_word(9'h001);
    push_char(8'h0C);
    wait_idle("wrap", 2000);
    drain();
    chk("wrap_strobes", n_strobes, 26);

    base = n_strobes;
    for (int i = 0; i < 16; i++) expect_word({1'b1, 8'(8'h61 + i)});
    expect_word(9'h0C0);
    for (int i = 16; i < 20; i++) expect_word({1'b1, 8'(8'h61 + i)});
    force_busy = 1'b1;
    @(negedge clock);
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (char_ready) begin
        char_in    = 8'(8'h61 + acc);
        char_valid = 1'b1;
        acc++;
      end else begin
        char_valid = 1'b0;
      end
      @(negedge clock);
    end
    char_valid = 1'b0;
    chk("hold_accepted", acc, 16);
    chk("hold_count", {27'b0, fifo_count}, 32'd16);
    chk("hold_char_ready", {31'b0, char_ready}, 32'd0);
    chk("hold_no_strobe", n_strobes - base, 0);
    force_busy = 1'b0;
    for (int i = acc; i < 20; i++) push_char(8'(8'h61 + i));
    wait_idle("hold", 2000);
    drain();
    chk("hold_strobes", n_strobes - base, 21);

    base = n_strobes;
    expect_word(9'h154);
    ignore_target = n_ign + 1;
    push_char(8'h54);
    wait_idle("retry", 1000);
    drain();
    chk("retry_strobes", n_strobes - base, 2);
    chk("retry_first_ignored", {31'b0, log_ign[base]}, 32'd1);
    chk("retry_gap", log_cyc[base + 1] - log_cyc[base], 65);

    resp_len = 40;
    base = n_strobes;
    expect_word(9'h155);
    for (int i = 0; i < 6; i++) push_char(8'(8'h55 + i));
    chk("mid_count", {27'b0, fifo_count}, 32'd5);
    repeat (3) @(negedge clock);
    chk("mid_strobes", n_strobes - base, 1);
    chk("mid_busy", {31'b0, lcd_busy}, 32'd1);
    drain();
    internal_reset = 1'b1;
    @(negedge clock);
    chk("rst2_count", {27'b0, fifo_count}, 32'd0);
    chk("rst2_data_ready", {31'b0, lcd_data_ready}, 32'd0);
    chk("rst2_d_in", {23'b0, lcd_d_in}, 32'd0);
    chk("rst2_char_ready", {31'b0, char_ready}, 32'd1);
    @(negedge clock);
    internal_reset = 1'b0;
    resp_len = 3;
    exp_q.delete();

    base = n_strobes;
    expect_word(9'h15A);
    push_char(8'h5A);
    repeat (30) @(negedge clock);
    chk("post_rst_no_strobe", n_strobes - base, 0);
    chk("post_rst_not_idle", {31'b0, idle}, 32'd0);
    force_busy = 1'b1;
    repeat (10) @(negedge clock);
    force_busy = 1'b0;
    wait_idle("reinit", 1000);
    drain();
    chk("reinit_strobes", n_strobes - base, 1);
    chk("exp_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
